// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, address type, arbiter states and pointer wrap helper
package fb_pkg;
  localparam int H_RES      = 320;
  localparam int V_RES      = 240;
  localparam int ADDR_W     = 20;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 4;
  localparam int FB_PIXELS  = H_RES * V_RES;
  typedef logic [ADDR_W-1:0] fb_addr_t;
  typedef enum logic [1:0] {IDLE, ISSUE_RD, ISSUE_WR} state_t;
  function automatic fb_addr_t next_addr(input fb_addr_t a);
    return (a == fb_addr_t'(FB_PIXELS - 1)) ? '0 : a + fb_addr_t'(1);
  endfunction
endpackage

// File: rtl/fb_xy_to_addr.sv
// fb_xy_to_addr: row/col to linear framebuffer address with out-of-range flag
module fb_xy_to_addr
  import fb_pkg::*;
(
  input  logic [9:0] row,
  input  logic [9:0] col,
  output fb_addr_t   addr,
  output logic       err
);
  always_comb begin
    addr = (fb_addr_t'(row) << 8) + (fb_addr_t'(row) << 6) + fb_addr_t'(col);
    err  = (row >= 10'(V_RES)) || (col >= 10'(H_RES));
  end
endmodule

// File: rtl/framebuffer_access_arbiter.sv
// framebuffer_access_arbiter: single-master SDRAM port shared by display reads and pixel writes
module framebuffer_access_arbiter
  import fb_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Rd_Req,
  input  logic              Rd_Frame_Start,
  output logic              Rd_Ack,
  output logic [ADDR_W-1:0] Rd_Address,
  input  logic              Wr_Req,
  input  logic              Wr_Mode,
  input  logic [9:0]        Wr_Row,
  input  logic [9:0]        Wr_Col,
  input  logic [DATA_W-1:0] Wr_Data,
  output logic              Wr_Ack,
  output logic              Wr_Err,
  output logic              Mem_Read,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_Write_Data,
  input  logic              Mem_Busy
);
  state_t            state_q, state_d;
  fb_addr_t          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, addr_q, addr_d, xy_addr, wr_tgt;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        starve_q, starve_d;
  logic              err_q, err_d, xy_err, wr_ok, rd_win, grant_rd, grant_wr, bad;

  fb_xy_to_addr u_xy (.row(Wr_Row), .col(Wr_Col), .addr(xy_addr), .err(xy_err));

  // a request that just got Wr_Err is still held this cycle; ignore it so it is not re-granted
  always_comb begin
    wr_ok    = Wr_Req && !err_q;
    rd_win   = Rd_Req && (!wr_ok || starve_q != 3'(STARVE_MAX));
    grant_rd = (state_q == IDLE) && rd_win;
    grant_wr = (state_q == IDLE) && wr_ok && !rd_win;
    Rd_Ack   = (state_q == ISSUE_RD) && !Mem_Busy;
    Wr_Ack   = (state_q == ISSUE_WR) && !Mem_Busy;
    wr_tgt   = Wr_Mode ? xy_addr : wr_ptr_q;
    bad      = Wr_Mode && xy_err;
    state_d  = grant_rd ? ISSUE_RD : (grant_wr && !bad) ? ISSUE_WR : (Rd_Ack || Wr_Ack) ? IDLE : state_q;
    addr_d   = grant_rd ? rd_ptr_q : grant_wr ? wr_tgt : addr_q;
    wdata_d  = grant_wr ? Wr_Data : wdata_q;
    err_d    = grant_wr && bad;
    rd_ptr_d = Rd_Frame_Start ? '0 : Rd_Ack ? next_addr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = Wr_Ack ? next_addr(addr_q) : wr_ptr_q;
    starve_d = (!Wr_Req || grant_wr) ? '0 : (grant_rd && wr_ok) ? starve_q + 3'd1 : starve_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign Mem_Read       = (state_q == ISSUE_RD);
  assign Mem_Write      = (state_q == ISSUE_WR);
  assign Mem_Address    = addr_q;
  assign Mem_Write_Data = wdata_q;
  assign Rd_Address     = rd_ptr_q;
  assign Wr_Err         = err_q;
endmodule

// File: tb/tb_framebuffer_access_arbiter.sv
// tb_framebuffer_access_arbiter: directed stimulus, transaction-level pointer model and per-cycle checker
module tb_framebuffer_access_arbiter;
  localparam int PIX = 320 * 240;
  logic        Clk, Reset, Rd_Req, Rd_Frame_Start, Rd_Ack, Wr_Req, Wr_Mode, Wr_Ack, Wr_Err;
  logic        Mem_Read, Mem_Write, Mem_Busy;
  logic [19:0] Rd_Address, Mem_Address;
  logic [9:0]  Wr_Row, Wr_Col;
  logic [15:0] Wr_Data, Mem_Write_Data;

  framebuffer_access_arbiter dut (
    .Clk(Clk), .Reset(Reset), .Rd_Req(Rd_Req), .Rd_Frame_Start(Rd_Frame_Start), .Rd_Ack(Rd_Ack),
    .Rd_Address(Rd_Address), .Wr_Req(Wr_Req), .Wr_Mode(Wr_Mode), .Wr_Row(Wr_Row), .Wr_Col(Wr_Col),
    .Wr_Data(Wr_Data), .Wr_Ack(Wr_Ack), .Wr_Err(Wr_Err), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_Address(Mem_Address), .Mem_Write_Data(Mem_Write_Data), .Mem_Busy(Mem_Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {byte k; int addr; int len; int cyc;} ev_t;
  ev_t lg[$];
  int checks = 0, failures = 0, cyc = 0, n_err = 0, slen = 0;
  int m_rd = 0, m_wr = 0, exp_wa = 0, exp_wd = 0;
  logic en = 1'b0, pv_hold = 1'b0;
  int pv_addr = 0, pv_data = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // model: read pointer counts accepted reads since reset/frame start; write pointer follows last written address
  always @(negedge Clk) if (en) begin
    cyc++;
    chk("rd_address", int'(Rd_Address), m_rd);
    chk("ack_exclusive", int'(Rd_Ack && Wr_Ack), 0);
    chk("err_ack_exclusive", int'(Wr_Err && Wr_Ack), 0);
    chk("strobe_exclusive", int'(Mem_Read && Mem_Write), 0);
    chk("rd_ack", int'(Rd_Ack), int'(Mem_Read && !Mem_Busy));
    chk("wr_ack", int'(Wr_Ack), int'(Mem_Write && !Mem_Busy));
    if (Mem_Read) chk("rd_mem_addr", int'(Mem_Address), m_rd);
    if (Mem_Write) begin
      chk("wr_mem_addr", int'(Mem_Address), exp_wa);
      chk("wr_mem_data", int'(Mem_Write_Data), exp_wd);
    end
    if (pv_hold && (Mem_Read || Mem_Write)) begin
      chk("hold_addr", int'(Mem_Address), pv_addr);
      chk("hold_data", int'(Mem_Write_Data), pv_data);
    end
    if (Wr_Err) n_err++;
    slen = (Mem_Read || Mem_Write) && !Reset ? slen + 1 : 0;
    if (!Reset && (Mem_Read || Mem_Write) && !Mem_Busy) begin
      lg.push_back('{Mem_Read ? byte'("R") : byte'("W"), int'(Mem_Address), slen, cyc});
      slen = 0;
    end
    if (Reset) begin
      m_rd = 0;
      m_wr = 0;
    end else begin
      if (Rd_Frame_Start) m_rd = 0;
      else if (Mem_Read && !Mem_Busy) m_rd = (m_rd + 1) % PIX;
      if (Mem_Write && !Mem_Busy) m_wr = (exp_wa + 1) % PIX;
    end
    pv_hold = (Mem_Read || Mem_Write) && Mem_Busy && !Reset;
    pv_addr = int'(Mem_Address);
    pv_data = int'(Mem_Write_Data);
  end

  task automatic rd_n(input int n);
    int got = 0;
    Rd_Req = 1'b1;
    for (int t = 0; t < 100 && got < n; t++) begin
      @(posedge Clk); #2;
      if (Rd_Ack) got++;
    end
    Rd_Req = 1'b0;
    chk("rd_handshake", got, n);
    @(posedge Clk); #2;
  endtask

  // res: 1 = acked, 2 = error, 0 = timed out
  task automatic wr(input logic mode, input int row, input int col, input int data, output int res);
    res = 0;
    exp_wa = mode ? row * 320 + col : m_wr;
    exp_wd = data;
    Wr_Mode = mode; Wr_Row = 10'(row); Wr_Col = 10'(col); Wr_Data = 16'(data); Wr_Req = 1'b1;
    for (int t = 0; t < 50 && res == 0; t++) begin
      @(posedge Clk); #2;
      res = Wr_Ack ? 1 : Wr_Err ? 2 : 0;
    end
    Wr_Req = 1'b0;
    if (res == 0) chk("wr_handshake_timeout", 0, 1);
    @(posedge Clk); #2;
  endtask

  task automatic wait_mem_write();
    int seen = 0;
    for (int t = 0; t < 20 && seen == 0; t++) begin
      @(posedge Clk); #2;
      seen = int'(Mem_Write);
    end
    chk("mem_write_seen", seen, 1);
  endtask

  initial begin
    int mark, r, e0;
    byte exp_k[6];
    exp_k = '{"R", "R", "R", "R", "W", "R"};
    Reset = 1'b1; Rd_Req = 1'b0; Rd_Frame_Start = 1'b0; Wr_Req = 1'b0; Wr_Mode = 1'b0;
    Wr_Row = '0; Wr_Col = '0; Wr_Data = '0; Mem_Busy = 1'b0;
    repeat (2) @(posedge Clk);
    #2; en = 1'b1;
    chk("reset_mem_read", int'(Mem_Read), 0);
    chk("reset_mem_write", int'(Mem_Write), 0);
    chk("reset_mem_addr", int'(Mem_Address), 0);
    chk("reset_rd_address", int'(Rd_Address), 0);
    chk("reset_wr_err", int'(Wr_Err), 0);
    Reset = 1'b0;
    // three back-to-back reads
    mark = lg.size();
    rd_n(3);
    chk("t1_count", lg.size() - mark, 3);
    if (lg.size() - mark == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_addr", lg[mark + i].addr, i);
        chk("t1_len", lg[mark + i].len, 1);
      end
      chk("t1_spacing_a", lg[mark + 1].cyc - lg[mark].cyc, 2);
      chk("t1_spacing_b", lg[mark + 2].cyc - lg[mark + 1].cyc, 2);
    end
    // row/col write stalled three cycles
    Mem_Busy = 1'b1;
    exp_wa = 645; exp_wd = 16'hABCD;
    Wr_Mode = 1'b1; Wr_Row = 10'd2; Wr_Col = 10'd5; Wr_Data = 16'hABCD; Wr_Req = 1'b1;
    wait_mem_write();
    repeat (3) @(posedge Clk);
    #1 Mem_Busy = 1'b0;
    #1 chk("t2_ack_4th", int'(Wr_Ack), 1);
    Wr_Req = 1'b0;
    @(posedge Clk); #2;
    chk("t2_addr", lg[$].addr, 645);
    chk("t2_len", lg[$].len, 4);
    // write pointer wrap
    wr(1'b1, 239, 318, 1, r);
    chk("t3_last_addr", lg[$].addr, 76798);
    wr(1'b0, 0, 0, 2, r);
    chk("t3_top_addr", lg[$].addr, 76799);
    wr(1'b0, 0, 0, 3, r);
    chk("t3_wrap_addr", lg[$].addr, 0);
    // out-of-range row and column
    e0 = n_err; mark = lg.size();
    wr(1'b1, 240, 0, 4, r);
    chk("t5_row_err", r, 2);
    wr(1'b1, 0, 320, 5, r);
    chk("t5_col_err", r, 2);
    repeat (3) @(posedge Clk); #2;
    chk("t5_err_pulses", n_err - e0, 2);
    chk("t5_no_write", lg.size() - mark, 0);
    wr(1'b0, 0, 0, 6, r);
    chk("t5_ptr_kept", lg[$].addr, 1);
    // both requesters held: starvation limit
    mark = lg.size();
    exp_wa = m_wr; exp_wd = 7;
    Wr_Mode = 1'b0; Wr_Data = 16'd7; Rd_Req = 1'b1; Wr_Req = 1'b1;
    r = 0;
    for (int t = 0; t < 100; t++) begin
      @(posedge Clk); #2;
      if (Wr_Ack) begin Wr_Req = 1'b0; r = 1; end
      else if (r == 1 && Rd_Ack) break;
    end
    Rd_Req = 1'b0; Wr_Req = 1'b0;
    @(posedge Clk); #2;
    chk("t4_count", lg.size() - mark, 6);
    if (lg.size() - mark == 6) for (int i = 0; i < 6; i++) chk("t4_grant", int'(lg[mark + i].k), int'(exp_k[i]));
    // frame start restarts the read stream
    Rd_Frame_Start = 1'b1;
    @(posedge Clk); #2;
    Rd_Frame_Start = 1'b0;
    rd_n(1);
    chk("frame_start_addr", lg[$].addr, 0);
    // reset during a stalled write
    Mem_Busy = 1'b1; mark = lg.size();
    exp_wa = m_wr; exp_wd = 8;
    Wr_Mode = 1'b0; Wr_Data = 16'd8; Wr_Req = 1'b1;
    wait_mem_write();
    @(posedge Clk); #2;
    Reset = 1'b1;
    @(posedge Clk); #2;
    chk("t6_write_dropped", int'(Mem_Write), 0);
    chk("t6_rd_ptr", int'(Rd_Address), 0);
    chk("t6_no_ack", int'(Wr_Ack), 0);
    Reset = 1'b0; Wr_Req = 1'b0; Mem_Busy = 1'b0;
    @(posedge Clk); #2;
    chk("t6_no_accept", lg.size() - mark, 0);
    wr(1'b0, 0, 0, 9, r);
    chk("t6_wr_ptr", lg[$].addr, 0);
    rd_n(1);
    chk("t6_rd_addr", lg[$].addr, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
